uart_rx_deserializer: RTL

- 8N1 UART receiver: idle-high, 1 start bit (low), 8 data bits LSB first, 1 stop bit (high).
- Pairs with the UART transmitter on the host link and shares its bit period (434 clocks = 115200 baud at 50 MHz).
- Delivers received bytes to the debugger command logic through a level-valid/ack holding register.
- Also provides a toggle output so toggle-style consumers need no handshake.

---
 rtl/uart_rx_deserializer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver with a level-valid/ack holding register and a toggle output.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting on every bit sample.
module uart_rx_deserializer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       rd_ack,
    output logic       rx_toggle,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    localparam logic [15:0] BIT_LOAD = 16'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    // The vote completes one cycle after the nominal sample point.
    localparam logic [15:0] START_LOAD = 16'(CLKS_PER_BIT / 2);
`else
    localparam logic [15:0] START_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
`endif

    logic [1:0] rst_sync_q;
    logic       rst_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_i = rst_sync_q[1];

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxs;
    logic                   samp;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    assign rxs    = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;

    assign hist_d = {hist_q[0], rxs};
    assign samp   = (rxs & hist_q[0]) | (rxs & hist_q[1]) |
                    (hist_q[0] & hist_q[1]);

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign samp = rxs;
`endif

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        tog_q, tog_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        busy_q, busy_d;
    logic        tmr_zero;

    assign tmr_zero = (timer_q == 16'd0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        tog_d   = tog_q;
        ferr_d  = 1'b0;
        ovr_d   = ovr_q;

        if (rd_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    timer_d = START_LOAD;
                end
            end
            S_START: begin
                if (!tmr_zero) begin
                    timer_d = timer_q - 16'd1;
                end else if (!samp) begin
                    state_d = S_DATA;
                    timer_d = BIT_LOAD;
                    idx_d   = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (!tmr_zero) begin
                    timer_d = timer_q - 16'd1;
                end else begin
                    shift_d[idx_q] = samp;
                    timer_d        = BIT_LOAD;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (!tmr_zero) begin
                    timer_d = timer_q - 16'd1;
                end else if (samp) begin
                    // A load in the ack cycle replaces the consumed byte cleanly.
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    tog_d   = ~tog_q;
                    if (valid_q && !rd_ack) begin
                        ovr_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            sync_q  <= '1;
            state_q <= S_IDLE;
            timer_q <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            tog_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            tog_q   <= tog_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign rx_toggle   = tog_q;
    assign framing_err = ferr_q;
    assign overrun     = ovr_q;
    assign busy        = busy_q;

endmodule
